// File: rtl/joypad_port.sv
// Two-pad controller port on the CPU bus: a shared strobe latch plus one
// parallel-load / serial-out shift register per pad. Optional turbo: JOYPAD_TURBO_EN.
module joypad_port #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h4016,
  parameter logic [6:0]            OPEN_BUS   = 7'h20,
  parameter int                    TURBO_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [REG_WIDTH-1:0]  din,
  output logic [REG_WIDTH-1:0]  dout,
  output logic                  sel,
  input  logic [7:0]            pad0_buttons,
  input  logic [7:0]            pad1_buttons,
  input  logic [1:0]            turbo_mask
);

  localparam logic [ADDR_WIDTH-1:0] PAD1_ADDR = ADDR_WIDTH'(BASE_ADDR + 1);

  logic       w_hit0;
  logic       w_hit1;
  logic       w_rd_ok;
  logic [7:0] w_eff0;
  logic [7:0] w_eff1;
  logic       w_rd_bit;
  logic       w_unused_bits;

  logic       r_strobe;
  logic [7:0] r_sr0;
  logic [7:0] r_sr1;
  logic [3:0] r_cnt0;
  logic [3:0] r_cnt1;

  assign w_hit0  = (addr == BASE_ADDR);
  assign w_hit1  = (addr == PAD1_ADDR);
  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign w_rd_ok = re && !we && (w_hit0 || w_hit1);

  assign w_unused_bits = ^{din[REG_WIDTH-1:1], turbo_mask};

`ifdef JOYPAD_TURBO_EN
  localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [TW-1:0] r_turbo_cnt;
  logic          r_phase;
  logic [1:0]    w_turbo_gate;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_turbo_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_turbo_cnt == TW'(TURBO_DIV - 1)) begin
      r_turbo_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_turbo_cnt <= r_turbo_cnt + 1'b1;
    end
  end

  // Turbo only gates A and B; the phase keeps running whatever the strobe does.
  assign w_turbo_gate = ~turbo_mask | {r_phase, r_phase};
  assign w_eff0 = pad0_buttons & {6'h3F, w_turbo_gate};
  assign w_eff1 = pad1_buttons & {6'h3F, w_turbo_gate};
`else
  assign w_eff0 = pad0_buttons;
  assign w_eff1 = pad1_buttons;
`endif

  always_comb begin
    w_rd_bit = 1'b1;
    if (r_strobe) begin
      w_rd_bit = w_hit0 ? w_eff0[0] : w_eff1[0];
    end else begin
      w_rd_bit = w_hit0 ? r_sr0[0] : r_sr1[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_strobe <= 1'b0;
      r_sr0    <= 8'hFF;
      r_sr1    <= 8'hFF;
      r_cnt0   <= 4'd8;
      r_cnt1   <= 4'd8;
      dout     <= '0;
      sel      <= 1'b0;
    end else begin
      dout <= '0;
      sel  <= 1'b0;

      if (we && w_hit0) begin
        r_strobe <= din[0];
      end

      // While strobed, reload every cycle; on the falling edge the last load simply stays.
      if (r_strobe) begin
        r_sr0  <= w_eff0;
        r_sr1  <= w_eff1;
        r_cnt0 <= 4'd0;
        r_cnt1 <= 4'd0;
      end

      if (w_rd_ok) begin
        sel  <= 1'b1;
        dout <= REG_WIDTH'({OPEN_BUS, w_rd_bit});
        if (!r_strobe) begin
          if (w_hit0) begin
            r_sr0 <= {1'b1, r_sr0[7:1]};
            if (r_cnt0 < 4'd8) begin
              r_cnt0 <= r_cnt0 + 4'd1;
            end
          end else begin
            r_sr1 <= {1'b1, r_sr1[7:1]};
            if (r_cnt1 < 4'd8) begin
              r_cnt1 <= r_cnt1 + 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/joypad_port.md
# joypad_port

Memory-mapped controller-port responder on the CPU data bus. It decodes CPU accesses to the two controller registers at `BASE_ADDR` (pad 0) and `BASE_ADDR+1` (pad 1). A CPU write sets the shared strobe latch. CPU reads return the controller buttons one bit per read, using an 8-bit parallel-load, serial-out shift register per pad. It sits beside `mem` on the `A`/`D`/`R_W_n` bus: it supplies `D` when selected, and `mem` serves all other addresses.

## Interface
- `BASE_ADDR`, 16'h4016, address of the pad 0 register; pad 1 is at `BASE_ADDR+1`.
- `ADDR_WIDTH`, 16, CPU address width.
- `REG_WIDTH`, 8, CPU data width.
- `OPEN_BUS`, 7'h20, value driven on `dout[7:1]` for every read.
- `TURBO_DIV`, 4, half-period of the turbo phase, in clk cycles; must be ≥1.

- `clk`  in  1  bus clock; same clock as `mem`.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  ADDR_WIDTH  CPU address.
- `we`  in  1  single-cycle write strobe, equal to `!R_W_n` qualified by the bus cycle.
- `re`  in  1  single-cycle read strobe.
- `din`  in  REG_WIDTH  write data.
- `dout`  out  REG_WIDTH  read data, registered.
- `sel`  out  1  high for one cycle while `dout` is valid; the top-level mux uses it to override `mem`.
- `pad0_buttons`  in  8  live buttons, active-high. Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- `pad1_buttons`  in  8  as above, for pad 1.
- `turbo_mask`  in  2  bit 0 = turbo on A, bit 1 = turbo on B; applies to both pads.

## Operation
- **Decode:** `hit0 = (addr == BASE_ADDR)`, `hit1 = (addr == BASE_ADDR+1)`.
- **Write:** `we && hit0` latches `strobe <= din[0]`.
  - A write to `hit1` is ignored.
  - Writes to any other address are ignored.
- **Strobe state (`strobe`=1):**
  - Each cycle, `sr0 <= eff(pad0_buttons)`, `sr1 <= eff(pad1_buttons)`, and both `cnt <= 0`.
  - A read returns bit 0 (A) of the live effective buttons.
  - A read causes no shift and no count change.
- **Falling edge:** on the 1→0 transition of `strobe`, the shift registers hold the values loaded on the last strobe=1 cycle. No additional load occurs.
- **Shift state (`strobe`=0), read of pad n:**
  - `dout <= {OPEN_BUS, sr_n[0]}`.
  - `sr_n <= {1'b1, sr_n[7:1]}`.
  - If `cnt_n < 8`, `cnt_n <= cnt_n + 1`; `cnt_n` saturates at 8.
  - Reads 1–8 return A, B, Select, Start, Up, Down, Left, Right. Read 9 onward returns 1 until the next strobe.
  - Pads shift independently; reading pad 0 never shifts pad 1.
- **Simultaneous events:**
  - `we` and `re` both high: the write is performed, the read is dropped, and `sel` stays 0.
  - Button inputs changing during shift state have no effect.
- **Reset mid-operation:**
  - `strobe <= 0`, `sr0`/`sr1 <= 8'hFF`, `cnt0`/`cnt1 <= 8`.
  - Any in-flight read is discarded.
  - Until the next strobe, reads return `{OPEN_BUS, 1}`.
- `eff(b) = b` without turbo; see Configuration.

## Timing
- Read latency is 1 cycle: `re` at edge N produces `dout`/`sel` valid after edge N+1, held for exactly one cycle.
- Outside a read, `dout` is 0 and `sel` is 0.
- A write takes effect at the next edge. A read in the cycle immediately after a write sees the new strobe value.
- Back-to-back reads on consecutive cycles are legal; each read shifts once.
- Values after reset:
  - `dout` = 0, `sel` = 0, `strobe` = 0.
  - Shift registers = 8'hFF, counters = 8.
  - Turbo counter = 0, turbo phase = 1.

## Configuration
- Macro: `JOYPAD_TURBO_EN`.
- **Defined:**
  - A free-running counter wraps every `TURBO_DIV` cycles and toggles `phase`.
  - `eff(b)[0] = b[0] & (~turbo_mask[0] | phase)`.
  - `eff(b)[1] = b[1] & (~turbo_mask[1] | phase)`.
  - All other bits pass through unchanged.
  - The counter runs regardless of strobe state. Reset sets counter = 0 and phase = 1.
- **Undefined:**
  - No counter is built.
  - `turbo_mask` is ignored, and `eff(b) = b`.

## Test plan
- Reset, then 10 reads of 0x4016 → each returns `dout`=0x41; `sel` is pulsed on every read.
- `pad0_buttons`=0xA5, write 0x01 then 0x00 to 0x4016, then 10 reads → `dout[0]` sequence is 1,0,1,0,0,1,0,1,1,1.
- `pad0`=0x01, `pad1`=0x80, strobe pulse, then alternate reads 0x4016/0x4017 ×8 each → pad 0 returns 1 then 0s; pad 1 returns seven 0s then 1. No cross-shifting occurs.
- Strobe held at 1 with `pad0` toggling 0x00↔0x01, with reads → `dout[0]` tracks the live A bit. After strobe falls, the first read returns the A value from the last strobe=1 cycle.
- After strobe, read 3 times, then assert `reset` for one cycle, then read → returns 0x41. A second strobe with `pad0`=0x02 then 2 reads → returns 0, then 1.
- `JOYPAD_TURBO_EN`, `TURBO_DIV`=4, `pad0`=0x01, `turbo_mask`=01; pulse strobe for 1 cycle at cycles 2, 6, 10, … (each followed by one read) → reads alternate between 1 and 0 every 4 cycles. Without the macro, every read returns 1.
